// File: rtl/tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_decoder
//
// Receive side of one DVI/TMDS colour channel. Each pixel clock it takes a
// 10-bit character from the deserializer and recovers the video-data-enable,
// the pixel byte and the 2-bit control code.
//
// It also aligns the word boundary. While searching, it counts consecutive
// control tokens. If no lock is found in time, it pulses BITSLIP. Once
// locked, it tracks the received running disparity and flags excursions.
//
// Ports:
//   CLK        pixel clock
//   RST        synchronous, active-high reset
//   ENC[9:0]   TMDS character from deserializer, bit 0 first-transmitted
//   VDE        decoded video-data-enable
//   VIDDATA    decoded pixel byte
//   CONTROL    decoded control code {C1,C0}
//   BITSLIP    one-cycle request to shift the deserializer word boundary
//   LOCKED     word alignment achieved
//   DISP_ERR   one-cycle pulse when the disparity bound is violated
//   ERR_COUNT  saturating count of DISP_ERR pulses since reset
// ---------------------------------------------------------------------------
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_SETTLE    = 4,
  parameter int UNLOCK_TIMEOUT = 65536,
  parameter int DISP_LIMIT     = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  ENC,
  output logic        VDE,
  output logic [7:0]  VIDDATA,
  output logic [1:0]  CONTROL,
  output logic        BITSLIP,
  output logic        LOCKED,
  output logic        DISP_ERR,
  output logic [15:0] ERR_COUNT
);

  localparam logic [1:0] ST_SEARCH    = 2'd0;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  localparam int TOK_W    = $clog2(LOCK_COUNT + 1);
  localparam int SRCH_W   = $clog2(SEARCH_TIMEOUT + 1);
  localparam int SETTLE_W = $clog2(SLIP_SETTLE + 1);
  localparam int IDLE_W   = $clog2(UNLOCK_TIMEOUT + 1);

  localparam logic [TOK_W-1:0]    TOK_LAST    = TOK_W'(LOCK_COUNT - 1);
  localparam logic [SRCH_W-1:0]   SEARCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(UNLOCK_TIMEOUT - 1);

  localparam logic signed [8:0] LIM_P = 9'(DISP_LIMIT);
  localparam logic signed [8:0] LIM_N = -LIM_P;

  logic [1:0]          state;
  logic [TOK_W-1:0]    tok_cnt;
  logic [SRCH_W-1:0]   search_timer;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [IDLE_W-1:0]   idle_timer;
  logic signed [7:0]   rd;

  logic                is_ctrl;
  logic [1:0]          ctrl_code;
  logic [7:0]          q;
  logic [7:0]          decoded;
  logic [3:0]          ones;
  logic signed [8:0]   rd_sum;
  logic                disp_over;
  logic signed [7:0]   rd_next;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_code = 2'b00;
    case (ENC)
      10'h354: ctrl_code = 2'b00;
      10'h0AB: ctrl_code = 2'b01;
      10'h154: ctrl_code = 2'b10;
      10'h2AB: ctrl_code = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase
  end

  // ENC[9] marks an inverted payload.
  // ENC[8] chooses XOR (1) or XNOR (0) chaining of adjacent bits.
  always_comb begin
    q          = ENC[9] ? ~ENC[7:0] : ENC[7:0];
    decoded    = 8'h00;
    decoded[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = ENC[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Each character contributes (ones - zeros) = 2*popcount - 10 to disparity.
  // The sum is formed in 9 bits so the out-of-range value is seen before
  // it is clamped back into the 8-bit accumulator.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, ENC[i]};
    end
    rd_sum    = {rd[7], rd} + $signed({4'b0000, ones, 1'b0}) - 9'sd10;
    disp_over = (rd_sum > LIM_P) || (rd_sum < LIM_N);
    if (rd_sum > LIM_P) begin
      rd_next = LIM_P[7:0];
    end else if (rd_sum < LIM_N) begin
      rd_next = LIM_N[7:0];
    end else begin
      rd_next = rd_sum[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_SEARCH;
      tok_cnt      <= '0;
      search_timer <= '0;
      settle_cnt   <= '0;
      idle_timer   <= '0;
      rd           <= '0;
      VDE          <= 1'b0;
      VIDDATA      <= 8'h00;
      CONTROL      <= 2'b00;
      BITSLIP      <= 1'b0;
      LOCKED       <= 1'b0;
      DISP_ERR     <= 1'b0;
      ERR_COUNT    <= 16'h0000;
    end else begin
      BITSLIP  <= 1'b0;
      DISP_ERR <= 1'b0;
      case (state)
        ST_SEARCH: begin
          VDE     <= 1'b0;
          VIDDATA <= 8'h00;
          CONTROL <= 2'b00;
          LOCKED  <= 1'b0;
          // Lock takes priority over a coinciding search timeout.
          // The token that completes the lock is already reported.
          if (is_ctrl && (tok_cnt == TOK_LAST)) begin
            state        <= ST_LOCKED;
            LOCKED       <= 1'b1;
            CONTROL      <= ctrl_code;
            tok_cnt      <= '0;
            search_timer <= '0;
            idle_timer   <= '0;
            rd           <= '0;
          end else if (search_timer == SEARCH_LAST) begin
            state        <= ST_SLIP_WAIT;
            BITSLIP      <= 1'b1;
            search_timer <= '0;
            tok_cnt      <= '0;
            settle_cnt   <= '0;
          end else begin
            search_timer <= search_timer + SRCH_W'(1);
            tok_cnt      <= is_ctrl ? (tok_cnt + TOK_W'(1)) : '0;
          end
        end

        ST_SLIP_WAIT: begin
          VDE     <= 1'b0;
          VIDDATA <= 8'h00;
          CONTROL <= 2'b00;
          LOCKED  <= 1'b0;
          if (settle_cnt == SETTLE_LAST) begin
            state        <= ST_SEARCH;
            settle_cnt   <= '0;
            tok_cnt      <= '0;
            search_timer <= '0;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        ST_LOCKED: begin
          if (is_ctrl) begin
            VDE        <= 1'b0;
            CONTROL    <= ctrl_code;
            idle_timer <= '0;
            rd         <= '0;
          end else if (idle_timer == IDLE_LAST) begin
            // A long run of data words with no token means alignment was lost.
            state        <= ST_SEARCH;
            LOCKED       <= 1'b0;
            VDE          <= 1'b0;
            VIDDATA      <= 8'h00;
            CONTROL      <= 2'b00;
            idle_timer   <= '0;
            rd           <= '0;
            tok_cnt      <= '0;
            search_timer <= '0;
          end else begin
            idle_timer <= idle_timer + IDLE_W'(1);
            VDE        <= 1'b1;
            VIDDATA    <= decoded;
            rd         <= rd_next;
            if (disp_over) begin
              DISP_ERR <= 1'b1;
              if (ERR_COUNT != 16'hFFFF) begin
                ERR_COUNT <= ERR_COUNT + 16'd1;
              end
            end
          end
        end

        default: begin
          state   <= ST_SEARCH;
          VDE     <= 1'b0;
          VIDDATA <= 8'h00;
          CONTROL <= 2'b00;
          LOCKED  <= 1'b0;
          rd      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_decoder
//
// Directed scoreboard bench for tmds_channel_decoder.
// The stimulus process drives one character per cycle on the falling edge.
// It queues the hand-computed response due after the next rising edge.
// A monitor pops and compares one entry shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_tmds_channel_decoder;

  logic        CLK;
  logic        RST;
  logic [9:0]  ENC;
  logic        VDE;
  logic [7:0]  VIDDATA;
  logic [1:0]  CONTROL;
  logic        BITSLIP;
  logic        LOCKED;
  logic        DISP_ERR;
  logic [15:0] ERR_COUNT;

  typedef struct packed {
    logic        vde;
    logic [7:0]  viddata;
    logic [1:0]  control;
    logic        bitslip;
    logic        locked;
    logic        disp_err;
    logic [15:0] err_count;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks;
  int    failures;
  exp_t  mon_e;
  string mon_t;

  localparam exp_t ZERO = '0;

  tmds_channel_decoder dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENC       (ENC),
    .VDE       (VDE),
    .VIDDATA   (VIDDATA),
    .CONTROL   (CONTROL),
    .BITSLIP   (BITSLIP),
    .LOCKED    (LOCKED),
    .DISP_ERR  (DISP_ERR),
    .ERR_COUNT (ERR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t ex(input logic vde, input logic [7:0] d,
                              input logic [1:0] c, input logic s,
                              input logic l, input logic de,
                              input logic [15:0] ec);
    exp_t e;
    e.vde       = vde;
    e.viddata   = d;
    e.control   = c;
    e.bitslip   = s;
    e.locked    = l;
    e.disp_err  = de;
    e.err_count = ec;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [9:0] enc,
                               input exp_t e, input string tag);
    @(negedge CLK);
    RST = rst;
    ENC = enc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    exp_t act;
    act = {VDE, VIDDATA, CONTROL, BITSLIP, LOCKED, DISP_ERR, ERR_COUNT};
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s @%0t: got vde=%0b data=%02h ctrl=%02b slip=%0b lock=%0b derr=%0b ecnt=%0d, expected vde=%0b data=%02h ctrl=%02b slip=%0b lock=%0b derr=%0b ecnt=%0d",
               tag, $time, act.vde, act.viddata, act.control, act.bitslip,
               act.locked, act.disp_err, act.err_count, e.vde, e.viddata,
               e.control, e.bitslip, e.locked, e.disp_err, e.err_count);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checkOutput(mon_e, mon_t);
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 10'h354, ZERO, "reset");
    applyStimulus(1'b1, 10'h354, ZERO, "reset");
  endtask

  task automatic doLock(input logic [15:0] ec);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 10'h354, ex(0, 8'h00, 2'b00, 0, 0, 0, 16'd0), "lock_wait");
    applyStimulus(1'b0, 10'h354, ex(0, 8'h00, 2'b00, 0, 1, 0, ec), "lock_8th");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    ENC      = 10'h000;

    $display("[TB] reset and lock on 0x354");
    doReset();
    doLock(16'd0);

    $display("[TB] data decode and control codes");
    applyStimulus(1'b0, 10'h100, ex(1, 8'h00, 2'b00, 0, 1, 0, 16'd0), "data_100");
    applyStimulus(1'b0, 10'h200, ex(1, 8'hFF, 2'b00, 0, 1, 1, 16'd1), "data_200_neg_disp");
    applyStimulus(1'b0, 10'h2AB, ex(0, 8'hFF, 2'b11, 0, 1, 0, 16'd1), "ctrl_11");
    applyStimulus(1'b0, 10'h0AB, ex(0, 8'hFF, 2'b01, 0, 1, 0, 16'd1), "ctrl_01");
    applyStimulus(1'b0, 10'h154, ex(0, 8'hFF, 2'b10, 0, 1, 0, 16'd1), "ctrl_10");
    applyStimulus(1'b0, 10'h100, ex(1, 8'h00, 2'b10, 0, 1, 0, 16'd1), "data_ctrl_hold");
    applyStimulus(1'b0, 10'h2F0, ex(1, 8'hEF, 2'b10, 0, 1, 0, 16'd1), "data_2F0");
    applyStimulus(1'b0, 10'h01F, ex(1, 8'hDF, 2'b10, 0, 1, 0, 16'd1), "data_01F");
    applyStimulus(1'b0, 10'h354, ex(0, 8'hDF, 2'b00, 0, 1, 0, 16'd1), "ctrl_00_hold");

    $display("[TB] interrupted token run");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 10'h354, ZERO, "tok_run1");
    applyStimulus(1'b0, 10'h100, ZERO, "tok_break");
    doLock(16'd0);

    $display("[TB] unlock after idle timeout");
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) applyStimulus(1'b0, 10'h01F, ZERO, "unlock_drop");
      else            applyStimulus(1'b0, 10'h01F, ex(1, 8'hDF, 2'b00, 0, 1, 0, 16'd0), "unlock_data");
    end
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) applyStimulus(1'b0, 10'h01F, ex(0, 8'h00, 2'b00, 1, 0, 0, 16'd0), "unlock_research_slip");
      else           applyStimulus(1'b0, 10'h01F, ZERO, "unlock_research");
    end

    $display("[TB] bitslip on constant data");
    doReset();
    for (int i = 0; i < 2060; i++) begin
      if (i == 1023 || i == 2051) applyStimulus(1'b0, 10'h100, ex(0, 8'h00, 2'b00, 1, 0, 0, 16'd0), "slip_pulse");
      else                        applyStimulus(1'b0, 10'h100, ZERO, "slip_idle");
    end

    $display("[TB] positive disparity run and reset");
    doReset();
    doLock(16'd0);
    applyStimulus(1'b0, 10'h3FF, ex(1, 8'h00, 2'b00, 0, 1, 0, 16'd0), "disp_first");
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 10'h3FF, ex(1, 8'h00, 2'b00, 0, 1, 1, 16'(k)), "disp_err");
    applyStimulus(1'b1, 10'h3FF, ZERO, "disp_mid_reset");
    applyStimulus(1'b0, 10'h3FF, ZERO, "disp_after_reset");
    applyStimulus(1'b0, 10'h3FF, ZERO, "disp_after_reset");

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
Receive-side counterpart of the per-channel DVI/TMDS encoder. It takes one 10-bit TMDS character per pixel clock from the deserializer and recovers VDE, 8-bit video data and the 2-bit control code. It also runs the word-alignment state machine that drives the deserializer bitslip until control tokens are seen consistently, and reports loss of lock and disparity errors. One instance is used per colour channel, between the ISERDES/deserializer and the pixel-domain video sink.

Parameters:
LOCK_COUNT, 8, consecutive control tokens needed to declare lock
SEARCH_TIMEOUT, 1024, cycles in SEARCH without lock before issuing a bitslip
SLIP_SETTLE, 4, cycles to ignore input after a bitslip pulse
UNLOCK_TIMEOUT, 65536, cycles in LOCKED without any control token before dropping lock
DISP_LIMIT, 10, magnitude of received running disparity that flags an error

Ports:
CLK  in  1  pixel clock
RST  in  1  reset, synchronous, active-high
ENC  in  10  TMDS character from deserializer, bit 0 first-transmitted
VDE  out  1  decoded video-data-enable
VIDDATA  out  8  decoded pixel byte
CONTROL  out  2  decoded control code {C1,C0}
BITSLIP  out  1  one-cycle request to deserializer to shift word boundary by 1 bit
LOCKED  out  1  word alignment achieved
DISP_ERR  out  1  one-cycle pulse: disparity bound violated
ERR_COUNT  out  16  saturating count of DISP_ERR pulses since reset

Behaviour:
- Reset (RST=1 at a CLK edge): all outputs 0; FSM to SEARCH; all counters and received disparity cleared. Reset mid-slip or mid-lock aborts immediately.
- Control tokens: 0x354 -> CONTROL 00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11. Any other word is data.
- Data decode: q = ENC[9] ? ~ENC[7:0] : ENC[7:0]; out[0] = q[0]; for i=1..7, out[i] = ENC[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Latency: 1 cycle, with registered outputs. The word sampled at edge N appears on the outputs after edge N.
- Output rules:
  - Not LOCKED: VDE=0, VIDDATA=0, CONTROL=00.
  - LOCKED with a control token: VDE=0, CONTROL=token code, VIDDATA holds.
  - LOCKED with data: VDE=1, VIDDATA=decoded byte, CONTROL holds.
- FSM:
  - SEARCH:
    - tokCnt counts consecutive control tokens; a data word clears it.
    - When tokCnt reaches LOCK_COUNT, go to LOCKED. LOCKED is asserted on the edge that accepts the LOCK_COUNTth token, and that token itself is output as a control code.
    - Otherwise the search timer increments each cycle. When it reaches SEARCH_TIMEOUT-1, assert BITSLIP for exactly 1 cycle, clear the timer and tokCnt, and go to SLIP_WAIT.
    - If lock and timeout coincide, lock wins and no BITSLIP is issued.
  - SLIP_WAIT: ignore ENC for SLIP_SETTLE cycles, then return to SEARCH with counters cleared. BITSLIP stays 0.
  - LOCKED:
    - Idle timer clears on every control token and increments otherwise.
    - When the idle timer reaches UNLOCK_TIMEOUT-1, go to SEARCH, deassert LOCKED, and force outputs to the not-locked values on the next edge.
- Disparity check (LOCKED only):
  - rd is a signed 8-bit accumulator.
  - On a control token, rd <= 0.
  - On a data word, rd <= rd + (2*popcount(ENC) - 10).
  - If |new rd| > DISP_LIMIT: pulse DISP_ERR for 1 cycle, clamp rd to ±DISP_LIMIT, and increment ERR_COUNT. ERR_COUNT saturates at 0xFFFF and does not wrap.
  - rd clears on leaving LOCKED.
- BITSLIP is never asserted in LOCKED or SLIP_WAIT. Consecutive BITSLIP pulses are at least SLIP_SETTLE+1 cycles apart.

Test Plan:
- Reset, then 8 consecutive 0x354 -> LOCKED=1 after the 8th edge, CONTROL=00, VDE=0, BITSLIP never asserted.
- Lock, then ENC=0x100 followed by 0x200 -> VDE=1 with VIDDATA=0x00 then 0xFF, each 1 cycle after input. Then 0x2AB -> VDE=0, CONTROL=11.
- Constant 0x100 from reset -> BITSLIP pulses 1 cycle at cycle 1024, next pulse at 1024+4+1024. LOCKED stays 0 throughout.
- Locked, then 7 tokens interrupted by one data word in a fresh SEARCH -> no lock until 8 uninterrupted tokens follow.
- Locked, then data only for 65536 cycles -> LOCKED drops, outputs return to 0, SEARCH timer restarts.
- Locked, then a stream of 0x3FF (popcount 10, +10 each) -> DISP_ERR on the 2nd word and every word after. ERR_COUNT increments per pulse. RST mid-stream clears ERR_COUNT, LOCKED and all outputs to 0 on the next edge.
